// File: rtl/fp_execute_stage5_if.sv
// fp_execute_stage5_if: shared types and the stage-4 to stage-5 bundle of the floating point pipeline
package fp_execute_stage5_pkg;
  localparam int MASK_WIDTH = 16;
  typedef logic [5:0] alu_op_t;
  localparam alu_op_t OP_FTOI = 6'h1b;
  localparam alu_op_t OP_FADD = 6'h20;
  localparam alu_op_t OP_FSUB = 6'h21;
  localparam alu_op_t OP_FMUL = 6'h22;
  localparam alu_op_t OP_ITOF = 6'h2a;
  typedef struct packed {
    alu_op_t    alu_op;
    logic [5:0] dest_reg;
    logic       has_dest;
    logic       dest_is_vector;
  } decoded_instruction_t;
  typedef logic [MASK_WIDTH-1:0] vector_lane_mask_t;
  typedef logic [1:0] local_thread_idx_t;
  typedef logic [1:0] subcycle_t;
endpackage

interface fp_execute_stage5_if import fp_execute_stage5_pkg::*; #(
  parameter int NUM_VECTOR_LANES = 16
);
  logic                        fx4_instruction_valid;
  decoded_instruction_t        fx4_instruction;
  vector_lane_mask_t           fx4_mask_value;
  local_thread_idx_t           fx4_thread_idx;
  subcycle_t                   fx4_subcycle;
  logic [NUM_VECTOR_LANES-1:0] fx4_result_is_inf;
  logic [NUM_VECTOR_LANES-1:0] fx4_result_is_nan;
  logic [NUM_VECTOR_LANES-1:0] fx4_add_result_sign;
  logic [NUM_VECTOR_LANES-1:0] fx4_logical_subtract;
  logic [NUM_VECTOR_LANES-1:0] fx4_mul_sign;
  logic [7:0]                  fx4_add_exponent [NUM_VECTOR_LANES];
  logic [31:0]                 fx4_add_significand [NUM_VECTOR_LANES];
  logic [5:0]                  fx4_norm_shift [NUM_VECTOR_LANES];
  logic [63:0]                 fx4_significand_product [NUM_VECTOR_LANES];
  logic [7:0]                  fx4_mul_exponent [NUM_VECTOR_LANES];
  logic                        wb_rollback_en;
  local_thread_idx_t           wb_rollback_thread_idx;
  logic                        fx5_instruction_valid;
  decoded_instruction_t        fx5_instruction;
  vector_lane_mask_t           fx5_mask_value;
  local_thread_idx_t           fx5_thread_idx;
  subcycle_t                   fx5_subcycle;
  logic [31:0]                 fx5_result [NUM_VECTOR_LANES];

  modport master (
    output fx4_instruction_valid, fx4_instruction, fx4_mask_value, fx4_thread_idx, fx4_subcycle,
    output fx4_result_is_inf, fx4_result_is_nan, fx4_add_result_sign, fx4_logical_subtract, fx4_mul_sign,
    output fx4_add_exponent, fx4_add_significand, fx4_norm_shift, fx4_significand_product, fx4_mul_exponent,
    output wb_rollback_en, wb_rollback_thread_idx,
    input  fx5_instruction_valid, fx5_instruction, fx5_mask_value, fx5_thread_idx, fx5_subcycle, fx5_result
  );

  modport slave (
    input  fx4_instruction_valid, fx4_instruction, fx4_mask_value, fx4_thread_idx, fx4_subcycle,
    input  fx4_result_is_inf, fx4_result_is_nan, fx4_add_result_sign, fx4_logical_subtract, fx4_mul_sign,
    input  fx4_add_exponent, fx4_add_significand, fx4_norm_shift, fx4_significand_product, fx4_mul_exponent,
    input  wb_rollback_en, wb_rollback_thread_idx,
    output fx5_instruction_valid, fx5_instruction, fx5_mask_value, fx5_thread_idx, fx5_subcycle, fx5_result
  );
endinterface

// File: rtl/fp_execute_stage5.sv
// fp_execute_stage5: normalize, round-to-nearest-even, special-case and pack one FP result per lane
module fp_execute_stage5 import fp_execute_stage5_pkg::*; #(
  parameter int NUM_VECTOR_LANES = 16
) (
  input logic               clk,
  input logic               reset_n,
  fp_execute_stage5_if.slave fx
);
  logic                 valid_d, valid_q;
  decoded_instruction_t instruction_d, instruction_q;
  vector_lane_mask_t    mask_d, mask_q;
  local_thread_idx_t    thread_d, thread_q;
  subcycle_t            subcycle_d, subcycle_q;
  logic [31:0]          result_d [NUM_VECTOR_LANES];
  logic [31:0]          result_q [NUM_VECTOR_LANES];
  logic                 is_mul, is_ftoi, is_add;

  // Path decode, rollback squash and sideband capture
  always_comb begin
    is_mul = fx.fx4_instruction.alu_op == OP_FMUL;
    is_ftoi = fx.fx4_instruction.alu_op == OP_FTOI;
    is_add = (fx.fx4_instruction.alu_op == OP_FADD) | (fx.fx4_instruction.alu_op == OP_FSUB)
           | (fx.fx4_instruction.alu_op == OP_ITOF);
    valid_d = fx.fx4_instruction_valid
            & ~(fx.wb_rollback_en & (fx.fx4_thread_idx == fx.wb_rollback_thread_idx));
    instruction_d = fx.fx4_instruction;
    mask_d = fx.fx4_mask_value;
    thread_d = fx.fx4_thread_idx;
    subcycle_d = fx.fx4_subcycle;
  end

  for (genvar l = 0; l < NUM_VECTOR_LANES; l++) begin : g_lane
    logic [31:0]       n, ftoi_mag, float_res, res;
    logic [63:0]       p;
    logic [22:0]       mant;
    logic [23:0]       mant_inc;
    logic              rnd, sticky, sign, nan, inf;
    logic signed [9:0] e_pre, e;
    logic              unused_lane;

    // Select the float path, round, and resolve special values in priority order
    always_comb begin
      n = fx.fx4_add_significand[l] << fx.fx4_norm_shift[l];
      p = fx.fx4_significand_product[l];
      nan = fx.fx4_result_is_nan[l];
      inf = fx.fx4_result_is_inf[l];
      mant = is_mul ? (p[47] ? p[46:24] : p[45:23]) : n[30:8];
      rnd = is_mul ? (p[47] ? p[23] : p[22]) : n[7];
      sticky = is_mul ? (p[47] ? |p[22:0] : |p[21:0]) : |n[6:0];
      e_pre = is_mul ? 10'(fx.fx4_mul_exponent[l]) + {9'd0, p[47]}
                     : 10'(fx.fx4_add_exponent[l]) + 10'd8 - 10'(fx.fx4_norm_shift[l]);
      mant_inc = {1'b0, mant} + {23'd0, rnd & (sticky | mant[0])};
      e = e_pre + {9'd0, mant_inc[23]};
      sign = is_mul ? fx.fx4_mul_sign[l] : fx.fx4_add_result_sign[l];
      ftoi_mag = fx.fx4_add_significand[l] >> fx.fx4_norm_shift[l];
      float_res = nan ? 32'h7fff_ffff
                : (inf | (e >= 10'sd255)) ? {sign, 8'hff, 23'd0}
                : (~is_mul & (fx.fx4_add_significand[l] == 32'd0)) ? 32'd0
                : (e <= 10'sd0) ? {sign, 31'd0}
                : {sign, e[7:0], mant_inc[22:0]};
      res = is_ftoi ? ((nan | inf) ? 32'h8000_0000
                      : (fx.fx4_add_result_sign[l] ? -ftoi_mag : ftoi_mag))
          : (is_mul | is_add) ? float_res : 32'd0;
    end

    assign unused_lane = ^{p[63:48], fx.fx4_logical_subtract[l]};
    assign result_d[l] = res;
    assign fx.fx5_result[l] = result_q[l];
  end

  // Output register: every field loads each cycle, cleared by async reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      instruction_q <= '0;
      mask_q <= '0;
      thread_q <= '0;
      subcycle_q <= '0;
      for (int i = 0; i < NUM_VECTOR_LANES; i++) result_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      instruction_q <= instruction_d;
      mask_q <= mask_d;
      thread_q <= thread_d;
      subcycle_q <= subcycle_d;
      for (int i = 0; i < NUM_VECTOR_LANES; i++) result_q[i] <= result_d[i];
    end
  end

  assign fx.fx5_instruction_valid = valid_q;
  assign fx.fx5_instruction = instruction_q;
  assign fx.fx5_mask_value = mask_q;
  assign fx.fx5_thread_idx = thread_q;
  assign fx.fx5_subcycle = subcycle_q;
endmodule

// File: tb/tb_fp_execute_stage5.sv
// tb_fp_execute_stage5: random and directed stimulus checked against a value-level rounding model
module tb_fp_execute_stage5;
  import fp_execute_stage5_pkg::*;
  localparam int L = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int checks = 0;
  int errors = 0;

  fp_execute_stage5_if #(.NUM_VECTOR_LANES(L)) fx();
  fp_execute_stage5 #(.NUM_VECTOR_LANES(L)) dut (.clk(clk), .reset_n(reset_n), .fx(fx));

  always #5 clk = ~clk;

  logic                 exp_valid;
  decoded_instruction_t exp_instr;
  vector_lane_mask_t    exp_mask;
  local_thread_idx_t    exp_thread;
  subcycle_t            exp_sub;
  logic [31:0]          exp_result [L];

  task automatic chk(input string nm, input int idx, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h at %0t", nm, idx, got, want, $time);
    end
  endtask

  // Value-level model: find the leading one, round the exact magnitude to 24 bits, then pack
  function automatic logic [31:0] model_lane(int l);
    logic [5:0]  op;
    logic [63:0] m, q, rem, half;
    logic [31:0] mag;
    logic        mulp, addp, sg;
    int          msb, e, drop;
    op = fx.fx4_instruction.alu_op;
    mulp = op == OP_FMUL;
    addp = op inside {OP_FADD, OP_FSUB, OP_ITOF};
    if (op == OP_FTOI) begin
      if (fx.fx4_result_is_nan[l] || fx.fx4_result_is_inf[l]) return 32'h8000_0000;
      mag = fx.fx4_add_significand[l] >> fx.fx4_norm_shift[l];
      return fx.fx4_add_result_sign[l] ? 32'd0 - mag : mag;
    end
    if (!mulp && !addp) return 32'd0;
    if (fx.fx4_result_is_nan[l]) return 32'h7fff_ffff;
    sg = mulp ? fx.fx4_mul_sign[l] : fx.fx4_add_result_sign[l];
    if (fx.fx4_result_is_inf[l]) return {sg, 8'hff, 23'd0};
    m = mulp ? fx.fx4_significand_product[l] : {32'd0, fx.fx4_add_significand[l]};
    if (m == 64'd0) return 32'd0;
    msb = 63;
    while (!m[msb]) msb--;
    e = mulp ? int'(fx.fx4_mul_exponent[l]) + msb - 46 : int'(fx.fx4_add_exponent[l]) + msb - 23;
    drop = msb - 23;
    if (drop <= 0) q = m << (-drop);
    else begin
      q = m >> drop;
      rem = m & ((64'd1 << drop) - 64'd1);
      half = 64'd1 << (drop - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end
    if (q == 64'h100_0000) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {sg, 8'hff, 23'd0};
    if (e <= 0) return {sg, 31'd0};
    return {sg, e[7:0], q[22:0]};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_valid <= 1'b0;
      exp_instr <= '0;
      exp_mask <= '0;
      exp_thread <= '0;
      exp_sub <= '0;
      for (int i = 0; i < L; i++) exp_result[i] <= 32'd0;
    end else begin
      exp_valid <= fx.fx4_instruction_valid
                && !(fx.wb_rollback_en && fx.fx4_thread_idx == fx.wb_rollback_thread_idx);
      exp_instr <= fx.fx4_instruction;
      exp_mask <= fx.fx4_mask_value;
      exp_thread <= fx.fx4_thread_idx;
      exp_sub <= fx.fx4_subcycle;
      for (int i = 0; i < L; i++) exp_result[i] <= model_lane(i);
    end
  end

  always @(negedge clk) begin
    chk("valid", 0, 64'(fx.fx5_instruction_valid), 64'(exp_valid));
    chk("instr", 0, 64'(fx.fx5_instruction), 64'(exp_instr));
    chk("mask", 0, 64'(fx.fx5_mask_value), 64'(exp_mask));
    chk("thread", 0, 64'(fx.fx5_thread_idx), 64'(exp_thread));
    chk("subcycle", 0, 64'(fx.fx5_subcycle), 64'(exp_sub));
    for (int i = 0; i < L; i++) chk("result", i, 64'(fx.fx5_result[i]), 64'(exp_result[i]));
  end

  task automatic drive_random(input logic force_valid);
    decoded_instruction_t ins;
    int k, msb;
    logic [23:0] a, b;
    k = $urandom_range(0, 5);
    ins.alu_op = k == 0 ? OP_FADD : k == 1 ? OP_FSUB : k == 2 ? OP_FMUL : k == 3 ? OP_FTOI
               : k == 4 ? OP_ITOF : 6'($urandom_range(0, 15));
    ins.dest_reg = 6'($urandom);
    ins.has_dest = 1'($urandom);
    ins.dest_is_vector = 1'($urandom);
    fx.fx4_instruction = ins;
    fx.fx4_instruction_valid = force_valid || $urandom_range(0, 3) != 0;
    fx.fx4_mask_value = 16'($urandom);
    fx.fx4_thread_idx = 2'($urandom);
    fx.fx4_subcycle = 2'($urandom);
    fx.wb_rollback_en = $urandom_range(0, 2) == 0;
    fx.wb_rollback_thread_idx = 2'($urandom);
    for (int i = 0; i < L; i++) begin
      msb = $urandom_range(0, 32);
      if (msb == 32) begin
        fx.fx4_add_significand[i] = 32'd0;
        fx.fx4_norm_shift[i] = 6'd32;
      end else begin
        fx.fx4_add_significand[i] = (32'd1 << msb) | ($urandom & ((32'd1 << msb) - 32'd1));
        fx.fx4_norm_shift[i] = 6'(31 - msb);
      end
      if (ins.alu_op == OP_FTOI) begin
        fx.fx4_add_significand[i] = $urandom;
        fx.fx4_norm_shift[i] = 6'($urandom_range(0, 40));
      end
      a = 24'($urandom) | 24'h80_0000;
      b = 24'($urandom) | 24'h80_0000;
      fx.fx4_significand_product[i] = 64'(a) * 64'(b);
      fx.fx4_add_exponent[i] = 8'($urandom);
      fx.fx4_mul_exponent[i] = 8'($urandom);
      fx.fx4_result_is_nan[i] = $urandom_range(0, 15) == 0;
      fx.fx4_result_is_inf[i] = $urandom_range(0, 15) == 0;
      fx.fx4_add_result_sign[i] = 1'($urandom);
      fx.fx4_mul_sign[i] = 1'($urandom);
      fx.fx4_logical_subtract[i] = 1'($urandom);
    end
  endtask

  task automatic directed(input string nm, input logic [5:0] op, input logic [31:0] sig,
                          input logic [7:0] aexp, input logic [5:0] sh, input logic sg,
                          input logic [63:0] prod, input logic [7:0] mexp, input logic nan,
                          input logic [1:0] thr, input logic rb_en, input logic [1:0] rb_thr,
                          input logic [31:0] want, input logic want_valid);
    decoded_instruction_t ins;
    ins = '0;
    ins.alu_op = op;
    fx.fx4_instruction = ins;
    fx.fx4_instruction_valid = 1'b1;
    fx.fx4_mask_value = 16'hffff;
    fx.fx4_thread_idx = thr;
    fx.fx4_subcycle = 2'd0;
    fx.wb_rollback_en = rb_en;
    fx.wb_rollback_thread_idx = rb_thr;
    for (int i = 0; i < L; i++) begin
      fx.fx4_add_significand[i] = sig;
      fx.fx4_add_exponent[i] = aexp;
      fx.fx4_norm_shift[i] = sh;
      fx.fx4_add_result_sign[i] = sg;
      fx.fx4_mul_sign[i] = sg;
      fx.fx4_significand_product[i] = prod;
      fx.fx4_mul_exponent[i] = mexp;
      fx.fx4_result_is_nan[i] = nan;
      fx.fx4_result_is_inf[i] = 1'b0;
      fx.fx4_logical_subtract[i] = op == OP_FSUB;
    end
    @(negedge clk);
    chk(nm, 5, 64'(fx.fx5_result[5]), 64'(want));
    chk({nm, "_valid"}, 0, 64'(fx.fx5_instruction_valid), 64'(want_valid));
    chk({nm, "_model"}, 5, 64'(exp_result[5]), 64'(want));
  endtask

  initial begin
    fx.fx4_instruction_valid = 1'b0;
    fx.fx4_instruction = '0;
    fx.fx4_mask_value = '0;
    fx.fx4_thread_idx = '0;
    fx.fx4_subcycle = '0;
    fx.wb_rollback_en = 1'b0;
    fx.wb_rollback_thread_idx = '0;
    for (int i = 0; i < L; i++) begin
      fx.fx4_add_significand[i] = '0;
      fx.fx4_add_exponent[i] = '0;
      fx.fx4_norm_shift[i] = '0;
      fx.fx4_significand_product[i] = '0;
      fx.fx4_mul_exponent[i] = '0;
    end
    fx.fx4_result_is_nan = '0;
    fx.fx4_result_is_inf = '0;
    fx.fx4_add_result_sign = '0;
    fx.fx4_mul_sign = '0;
    fx.fx4_logical_subtract = '0;
    #1 reset_n = 1'b0;
    drive_random(1'b1);
    @(negedge clk);
    drive_random(1'b1);
    @(negedge clk);
    chk("rst_valid", 0, 64'(fx.fx5_instruction_valid), 64'd0);
    chk("rst_result", 0, 64'(fx.fx5_result[0]), 64'd0);
    reset_n = 1'b1;
    directed("fadd_1p1", OP_FADD, 32'h0100_0000, 8'd127, 6'd7, 1'b0, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h4000_0000, 1'b1);
    directed("rnd_carry", OP_FADD, 32'h01ff_ffff, 8'd127, 6'd7, 1'b0, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h4080_0000, 1'b1);
    directed("rnd_down", OP_FADD, 32'h00ff_ffff, 8'd127, 6'd8, 1'b0, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h3fff_ffff, 1'b1);
    directed("tie_even", OP_FADD, 32'h0100_0001, 8'd127, 6'd7, 1'b0, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h4000_0000, 1'b1);
    directed("tie_odd", OP_FADD, 32'h0100_0003, 8'd127, 6'd7, 1'b0, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h4000_0002, 1'b1);
    directed("fmul", OP_FMUL, 32'h0100_0000, 8'd0, 6'd7, 1'b0, 64'h0000_9000_0000_0000, 8'd127, 1'b0, 2'd0, 1'b0, 2'd0, 32'h4010_0000, 1'b1);
    directed("ovf", OP_FADD, 32'h0100_0000, 8'd254, 6'd7, 1'b0, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h7f80_0000, 1'b1);
    directed("cancel", OP_FSUB, 32'h0, 8'd127, 6'd32, 1'b0, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b1);
    directed("nan", OP_FADD, 32'h0100_0000, 8'd127, 6'd7, 1'b0, 64'd0, 8'd0, 1'b1, 2'd0, 1'b0, 2'd0, 32'h7fff_ffff, 1'b1);
    directed("ftoi", OP_FTOI, 32'h00c0_0000, 8'd0, 6'd21, 1'b1, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'hffff_fffa, 1'b1);
    directed("uflow", OP_FADD, 32'h0080_0000, 8'd0, 6'd8, 1'b1, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h8000_0000, 1'b1);
    directed("other_op", 6'h05, 32'h0100_0000, 8'd127, 6'd7, 1'b0, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b1);
    directed("rb_hit", OP_FADD, 32'h0100_0000, 8'd127, 6'd7, 1'b0, 64'd0, 8'd0, 1'b0, 2'd2, 1'b1, 2'd2, 32'h4000_0000, 1'b0);
    directed("rb_miss", OP_FADD, 32'h0100_0000, 8'd127, 6'd7, 1'b0, 64'd0, 8'd0, 1'b0, 2'd2, 1'b1, 2'd1, 32'h4000_0000, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      drive_random(1'b0);
      @(negedge clk);
    end
    drive_random(1'b1);
    @(negedge clk);
    drive_random(1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 0, 64'(fx.fx5_instruction_valid), 64'd0);
    chk("mid_rst_result", 0, 64'(fx.fx5_result[0]), 64'd0);
    chk("mid_rst_mask", 0, 64'(fx.fx5_mask_value), 64'd0);
    chk("mid_rst_thread", 0, 64'(fx.fx5_thread_idx), 64'd0);
    chk("mid_rst_instr", 0, 64'(fx.fx5_instruction), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    directed("after_rst", OP_FADD, 32'h0100_0000, 8'd127, 6'd7, 1'b0, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h4000_0000, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
